bictr_cmd_seq: RTL



---
 rtl/bictr_cmd_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bictr_cmd_seq.sv
// Command sequencer driving a decoded bidirectional counter, with a shadow count and wrap counter.
// Optional carry cross-check enabled by defining BICTR_SEQ_CARRY_CHECK_EN.
`timescale 1ns/1ps
module bictr_cmd_seq #(
  parameter int WIDTH = 8,
  parameter int STEPW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [STEPW-1:0] cmd_arg,
  output logic             load,
  output logic             cen,
  output logic             count_up_dwn,
  output logic [WIDTH-1:0] data_preset,
  input  logic             ctr_carry,
  output logic [WIDTH-1:0] exp_count,
  output logic [7:0]       wrap_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]       OP_NOP   = 2'b00;
  localparam logic [1:0]       OP_LOAD  = 2'b01;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STEPW-1:0] ZERO_S   = {STEPW{1'b0}};
  localparam logic [STEPW-1:0] ONE_S    = {{(STEPW-1){1'b0}}, 1'b1};

  state_t             state_r, state_nx_s;
  logic [STEPW-1:0]   remaining_r;
  logic               cmd_ready_r, load_r, cen_r, dir_r, busy_r, done_r, err_r;
  logic [WIDTH-1:0]   preset_r, exp_count_r;
  logic [7:0]         wrap_cnt_r;
  logic               accept_s, pred_carry_s, count_cmd_s;

  assign accept_s     = cmd_valid & cmd_ready_r;
  assign count_cmd_s  = cmd_op[1] & (cmd_arg != ZERO_S);
  // Carry the counter must raise this cycle, judged from the pre-update shadow.
  assign pred_carry_s = (dir_r & (exp_count_r == ALL_ONES)) | (~dir_r & (exp_count_r == ZERO_W));

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_nx_s = ST_IDLE;
        end else if (cmd_op == OP_LOAD) begin
          state_nx_s = ST_LOAD;
        end else if ((cmd_op == OP_NOP) || (cmd_arg == ZERO_S)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_LOAD: state_nx_s = ST_DONE;
      ST_RUN: begin
        if (remaining_r == ONE_S) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register and control strobes, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      load_r      <= 1'b0;
      cen_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cmd_ready_r <= (state_nx_s == ST_IDLE);
      load_r      <= (state_nx_s == ST_LOAD);
      cen_r       <= (state_nx_s == ST_RUN);
      busy_r      <= (state_nx_s != ST_IDLE);
      done_r      <= (state_nx_s == ST_DONE);
    end
  end

  // Latched command data: preset value, direction and remaining step count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preset_r    <= ZERO_W;
      dir_r       <= 1'b1;
      remaining_r <= ZERO_S;
    end else begin
      if (accept_s && (cmd_op == OP_LOAD)) begin
        preset_r <= cmd_arg[WIDTH-1:0];
      end
      if (accept_s && count_cmd_s) begin
        dir_r       <= ~cmd_op[0];
        remaining_r <= cmd_arg;
      end else if (state_r == ST_RUN) begin
        remaining_r <= remaining_r - ONE_S;
      end
    end
  end

  // Shadow counter, updated on the same edge the real counter samples load/cen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_count_r <= ZERO_W;
      wrap_cnt_r  <= 8'd0;
    end else if (load_r) begin
      exp_count_r <= preset_r;
    end else if (cen_r) begin
      exp_count_r <= dir_r ? (exp_count_r + ONE_W) : (exp_count_r - ONE_W);
      if (pred_carry_s && (wrap_cnt_r != 8'hFF)) begin
        wrap_cnt_r <= wrap_cnt_r + 8'd1;
      end
    end
  end

`ifdef BICTR_SEQ_CARRY_CHECK_EN
  // Sticky flag: counter carry disagreed with the shadow prediction in a run cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (cen_r && (ctr_carry != pred_carry_s)) begin
      err_r <= 1'b1;
    end
  end
`else
  logic unused_carry_s;
  assign unused_carry_s = ctr_carry;
  assign err_r          = 1'b0;
`endif

  assign cmd_ready    = cmd_ready_r;
  assign load         = load_r;
  assign cen          = cen_r;
  assign count_up_dwn = dir_r;
  assign data_preset  = preset_r;
  assign exp_count    = exp_count_r;
  assign wrap_cnt     = wrap_cnt_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;

endmodule
